pdm_tx: RTL and testbench

PDM_TX -- requirements
Module: pdm_tx

---
 rtl/pdm_pkg.sv | 29 ++
 rtl/pdm_sdm_core.sv | 53 +++++
 rtl/pdm_tx.sv | 102 ++++++++++
 tb/tb_pdm_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM transmitter types, full-scale constant and saturating add
// Used by pdm_tx and pdm_sdm_core; PDM_TX_ORDER2_EN is consumed in pdm_sdm_core.
package pdm_pkg;

   localparam int PCM_W_DEFAULT = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pdm_state_e;

   // Modulator feedback magnitude FS = 2^(pcm_w-1), one LSB above the largest positive sample.
   function automatic longint full_scale(input int pcm_w);
      return longint'(1) <<< (pcm_w - 1);
   endfunction

   function automatic longint sat_add(input longint a, input longint b, input int w);
      longint s;
      longint hi;
      longint lo;
      s  = a + b;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/pdm_sdm_core.sv
// rtl/pdm_sdm_core.sv - sigma-delta modulator: integrators, feedback, bit decision per step
// PDM_TX_ORDER2_EN adds the second integrator; default build is first-order.
module pdm_sdm_core
   import pdm_pkg::*;
#(
   parameter int PCM_W = PCM_W_DEFAULT,
   parameter int ACC_W = PCM_W + 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    step,
   input  logic signed [PCM_W-1:0] sample,
   input  logic                    prev_bit,
   output logic                    pdm_bit
);
   localparam longint FS_VAL = full_scale(PCM_W);

   longint fb;
   logic signed [ACC_W-1:0] i1;
   logic signed [ACC_W-1:0] i1_next;

   assign fb      = prev_bit ? FS_VAL : -FS_VAL;
   assign i1_next = ACC_W'(sat_add(longint'(i1), longint'(sample) - fb, ACC_W));

`ifdef PDM_TX_ORDER2_EN
   logic signed [ACC_W-1:0] i2;
   logic signed [ACC_W-1:0] i2_next;

   assign i2_next = ACC_W'(sat_add(longint'(i2), longint'(i1_next) - fb, ACC_W));
   assign pdm_bit = ~i2_next[ACC_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i1 <= '0;
         i2 <= '0;
      end else if (step) begin
         i1 <= i1_next;
         i2 <= i2_next;
      end
   end
`else
   assign pdm_bit = ~i1_next[ACC_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i1 <= '0;
      end else if (step) begin
         i1 <= i1_next;
      end
   end
`endif

endmodule

// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - PDM transmitter: micro_clk sync/edge detect, slot select, sample buffer, IDLE/RUN FSM
// PDM_TX_ORDER2_EN selects the second-order modulator inside pdm_sdm_core.
module pdm_tx
   import pdm_pkg::*;
#(
   parameter int PCM_W = PCM_W_DEFAULT,
   parameter int OSR   = 64,
   parameter int ACC_W = PCM_W + 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [PCM_W-1:0] pcm_data,
   input  logic                    pcm_valid,
   output logic                    pcm_ready,
   input  logic                    micro_clk,
   input  logic                    sel_lr,
   output logic                    pdm_o,
   output logic                    pdm_oe,
   output logic                    underrun
);
   localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   logic mclk_s1;
   logic mclk_s2;
   logic mclk_d;
   logic active;
   logic step;
   logic boundary;
   logic accept;
   logic core_bit;
   logic hold_valid;
   logic signed [PCM_W-1:0] hold_data;
   logic signed [PCM_W-1:0] cur_data;
   logic [CNT_W-1:0] cnt;
   pdm_state_e state;

   assign active    = sel_lr ? (mclk_d & ~mclk_s2) : (mclk_s2 & ~mclk_d);
   assign step      = active && (state == ST_RUN);
   assign boundary  = step && (cnt == CNT_LAST);
   assign pcm_ready = ~hold_valid;
   assign accept    = pcm_valid & pcm_ready;

   // oe is registered so it moves on the same clk as pdm_o.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mclk_s1 <= 1'b0;
         mclk_s2 <= 1'b0;
         mclk_d  <= 1'b0;
         pdm_oe  <= 1'b0;
      end else begin
         mclk_s1 <= micro_clk;
         mclk_s2 <= mclk_s1;
         mclk_d  <= mclk_s2;
         pdm_oe  <= (mclk_s2 == ~sel_lr);
      end
   end

   // An empty holding register at a boundary takes pcm_data directly when offered that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         cur_data   <= '0;
         cnt        <= '0;
         underrun   <= 1'b0;
         pdm_o      <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (state == ST_IDLE && accept) state <= ST_RUN;
         if (step) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (boundary) begin
            if (hold_valid) begin
               cur_data   <= hold_data;
               hold_valid <= 1'b0;
            end else if (pcm_valid) begin
               cur_data <= pcm_data;
            end else begin
               underrun <= 1'b1;
            end
         end else if (accept) begin
            hold_data  <= pcm_data;
            hold_valid <= 1'b1;
         end
         if (active) pdm_o <= (state == ST_RUN) ? core_bit : ~pdm_o;
      end
   end

   pdm_sdm_core #(
      .PCM_W(PCM_W),
      .ACC_W(ACC_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .step    (step),
      .sample  (cur_data),
      .prev_bit(pdm_o),
      .pdm_bit (core_bit)
   );

endmodule

// File: tb/tb_pdm_tx.sv
// tb/tb_pdm_tx.sv - directed self-checking bench for pdm_tx (PDM_TX_ORDER2_EN adds the order-2 case)
module tb_pdm_tx;
   logic clk;
   logic rst;
   logic signed [15:0] pcm_data;
   logic pcm_valid;
   logic pcm_ready;
   logic micro_clk;
   logic sel_lr;
   logic pdm_o;
   logic pdm_oe;
   logic underrun;

   int checks;
   int errors;
   int ur_cnt;

   pdm_tx #(.PCM_W(16), .OSR(64), .ACC_W(20)) dut (
      .clk      (clk),
      .rst      (rst),
      .pcm_data (pcm_data),
      .pcm_valid(pcm_valid),
      .pcm_ready(pcm_ready),
      .micro_clk(micro_clk),
      .sel_lr   (sel_lr),
      .pdm_o    (pdm_o),
      .pdm_oe   (pdm_oe),
      .underrun (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

   // One micro_clk period per edge (16 clk); samples 5 clk after each pin edge.
   task automatic run_edges(input int n, output int ones, output int oe_bad);
      ones   = 0;
      oe_bad = 0;
      for (int i = 0; i < n; i++) begin
         micro_clk = 1'b1;
         #50;
         if (pdm_oe !== ~sel_lr) oe_bad++;
         if (!sel_lr && pdm_o === 1'b1) ones++;
         #30;
         micro_clk = 1'b0;
         #50;
         if (pdm_oe !== sel_lr) oe_bad++;
         if (sel_lr && pdm_o === 1'b1) ones++;
         #30;
      end
   endtask

   task automatic test_reset;
      checks++; if (pdm_o !== 1'b0) begin errors++; $display("FAIL reset_pdm_o got=%b want=0", pdm_o); end
      checks++; if (pdm_oe !== 1'b0) begin errors++; $display("FAIL reset_pdm_oe got=%b want=0", pdm_oe); end
      checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL reset_pcm_ready got=%b want=1", pcm_ready); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b want=0", underrun); end
   endtask

   task automatic test_latency;
      micro_clk = 1'b1;
      #17;
      checks++; if (pdm_o !== 1'b0) begin errors++; $display("FAIL latency_before got=%b want=0", pdm_o); end
      #10;
      checks++; if (pdm_o !== 1'b1) begin errors++; $display("FAIL latency_after got=%b want=1", pdm_o); end
      checks++; if (pdm_oe !== 1'b1) begin errors++; $display("FAIL latency_oe got=%b want=1", pdm_oe); end
      #53;
      micro_clk = 1'b0;
      #80;
   endtask

   task automatic test_zero_density;
      int ones, ob;
      pcm_data  = 16'sd0;
      pcm_valid = 1'b1;
      run_edges(128, ones, ob);
      run_edges(64, ones, ob);
      checks++; if (ones < 31 || ones > 33) begin errors++; $display("FAIL zero_density ones=%0d want=32+/-1", ones); end
      checks++; if (ob != 0) begin errors++; $display("FAIL zero_oe bad=%0d want=0", ob); end
   endtask

   task automatic test_pos_half;
      int ones, ob;
      pcm_data = 16'sh4000;
      run_edges(192, ones, ob);
      run_edges(64, ones, ob);
      checks++; if (ones < 47 || ones > 49) begin errors++; $display("FAIL half_density ones=%0d want=48+/-1", ones); end
      checks++; if (ob != 0) begin errors++; $display("FAIL half_oe bad=%0d want=0", ob); end
   endtask

   task automatic test_neg_fs;
      int ones, ob;
      pcm_data = 16'sh8000;
      run_edges(192, ones, ob);
      run_edges(64, ones, ob);
      checks++; if (ones != 0) begin errors++; $display("FAIL negfs_density ones=%0d want=0", ones); end
   endtask

   task automatic test_underrun(output int b);
      int ones, ob, o, u0, ustart, late_ones;
      pcm_data = 16'sd0;
      run_edges(192, ones, ob);
      pcm_valid = 1'b0;
      b         = -1;
      late_ones = 0;
      ustart    = ur_cnt;
      for (int i = 0; i < 128; i++) begin
         u0 = ur_cnt;
         run_edges(1, o, ob);
         if (ur_cnt != u0) b = i;
         if (i >= 64) late_ones += o;
      end
      checks++; if (ur_cnt - ustart != 1) begin errors++; $display("FAIL underrun_pulses got=%0d want=1", ur_cnt - ustart); end
      checks++; if (b < 64) begin errors++; $display("FAIL underrun_edge got=%0d want=64..127", b); end
      checks++; if (late_ones < 31 || late_ones > 33) begin errors++; $display("FAIL underrun_density ones=%0d want=32+/-1", late_ones); end
   endtask

   task automatic test_bypass(input int b);
      int ones, ob, u0, pos;
      pos = (b < 64) ? 64 : b;
      run_edges(pos + 64 - 128, ones, ob);
      pcm_data = 16'sh8000;
      u0 = ur_cnt;
      micro_clk = 1'b1;
      #20;
      pcm_valid = 1'b1;
      #10;
      pcm_valid = 1'b0;
      #20;
      checks++; if (ur_cnt != u0) begin errors++; $display("FAIL bypass_underrun got=%0d want=%0d", ur_cnt, u0); end
      checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got=%b want=1", pcm_ready); end
      #30;
      micro_clk = 1'b0;
      #80;
      run_edges(8, ones, ob);
      run_edges(56, ones, ob);
      checks++; if (ones != 0) begin errors++; $display("FAIL bypass_sample ones=%0d want=0", ones); end
   endtask

   task automatic test_sel_lr;
      int ones, ob;
      logic a1, a2, f1, f2;
      pcm_data  = 16'sd0;
      pcm_valid = 1'b1;
      run_edges(192, ones, ob);
      sel_lr = 1'b1;
      micro_clk = 1'b1;
      #17 a1 = pdm_o;
      #10 a2 = pdm_o;
      #53;
      micro_clk = 1'b0;
      #17 f1 = pdm_o;
      #10 f2 = pdm_o;
      #53;
      checks++; if (a2 !== a1) begin errors++; $display("FAIL sel_rise_static got=%b want=%b", a2, a1); end
      checks++; if (f2 !== ~f1) begin errors++; $display("FAIL sel_fall_update got=%b want=%b", f2, ~f1); end
      run_edges(64, ones, ob);
      checks++; if (ones < 31 || ones > 33) begin errors++; $display("FAIL sel_density ones=%0d want=32+/-1", ones); end
      checks++; if (ob != 0) begin errors++; $display("FAIL sel_oe bad=%0d want=0", ob); end
   endtask

`ifdef PDM_TX_ORDER2_EN
   task automatic test_order2;
      int ones, ob;
      pcm_data = 16'sh7FFF;
      run_edges(192, ones, ob);
      run_edges(64, ones, ob);
      checks++; if (ones < 63) begin errors++; $display("FAIL order2_density ones=%0d want=64+/-1", ones); end
   endtask
`endif

   task automatic test_reset_mid;
      int o, ob;
      run_edges(20, o, ob);
      rst = 1'b1;
      #1;
      checks++; if (pdm_o !== 1'b0) begin errors++; $display("FAIL midrst_pdm_o got=%b want=0", pdm_o); end
      checks++; if (pdm_oe !== 1'b0) begin errors++; $display("FAIL midrst_pdm_oe got=%b want=0", pdm_oe); end
      checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", pcm_ready); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got=%b want=0", underrun); end
      #9;
      pcm_valid = 1'b0;
      sel_lr    = 1'b0;
      #20;
      rst = 1'b0;
      #20;
      for (int i = 0; i < 4; i++) begin
         run_edges(1, o, ob);
         checks++;
         if (o != ((i % 2 == 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL idle_pattern_%0d got=%0d want=%0d", i, o, (i % 2 == 0) ? 1 : 0);
         end
      end
   endtask

   initial begin
      int b;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      micro_clk = 1'b0;
      sel_lr    = 1'b0;
      pcm_valid = 1'b0;
      pcm_data  = 16'sd0;
      #2;
      #20;
      test_reset();
      rst = 1'b0;
      #20;
      test_latency();
      test_zero_density();
      test_pos_half();
      test_neg_fs();
      test_underrun(b);
      test_bypass(b);
      test_sel_lr();
`ifdef PDM_TX_ORDER2_EN
      test_order2();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
